muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit_if.sv | 27 ++
 rtl/muldiv_unit.sv | 216 +++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 385 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: operand, control and result bundle between the pipeline and
// the iterative multiply/divide unit.
interface muldiv_unit_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] busA;
    logic [31:0] busB;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;

    // Pipeline side: launches operations, performs MTHI/MTLO, reads HI/LO.
    modport master (
        output start, op, busA, busB, hi_we, lo_we, wdata,
        input  hi, lo, busy, done
    );

    // Unit side.
    modport slave (
        input  start, op, busA, busB, hi_we, lo_we, wdata,
        output hi, lo, busy, done
    );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: 32-iteration shift-add multiplier / restoring divider owning the
// architectural HI/LO registers. All state moves on the falling clock edge so
// results land on the same edge as register-file writes.
// Optional feature: define MULDIV_DIV_EN to build DIV/DIVU; without it only
// MULT/MULTU are accepted and no divider logic exists.
module muldiv_unit (
    input  logic         clk,
    input  logic         clrn,
    muldiv_unit_if.slave mdu
);
    localparam int unsigned W     = 32;
    localparam int unsigned CNT_W = 5;
    localparam int unsigned LAST  = 31;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t           state, stateNext;
    logic [CNT_W-1:0] cnt, cntNext;
    logic [W-1:0]     magB, magBNext;
    logic             negRes, negResNext;
    logic [2*W-1:0]   acc, accNext;
    logic [W-1:0]     hiR, hiNext;
    logic [W-1:0]     loR, loNext;
    logic             busyR, busyNext;
    logic             doneR, doneNext;

    logic             opSigned;
    logic             aNeg;
    logic             bNeg;
    logic [W-1:0]     magAIn;
    logic [W-1:0]     magBIn;
    logic             opValid;
    logic             acceptStart;

    logic [W:0]       mulSum;
    logic [2*W-1:0]   mulStep;
    logic [2*W-1:0]   prodFix;

`ifdef MULDIV_DIV_EN
    logic             isDiv, isDivNext;
    logic             negRem, negRemNext;
    logic [W-1:0]     rawA, rawANext;
    logic [W:0]       divUpper;
    logic             divGeq;
    logic [W-1:0]     divDiff;
    logic [2*W-1:0]   divStep;
    logic [W-1:0]     quotFix;
    logic [W-1:0]     remFix;
`endif

    // Decode launch request and form operand magnitudes and sign flags.
    always_comb begin
        opSigned = ~mdu.op[0];
        aNeg     = opSigned & mdu.busA[W-1];
        bNeg     = opSigned & mdu.busB[W-1];
        magAIn   = aNeg ? -mdu.busA : mdu.busA;
        magBIn   = bNeg ? -mdu.busB : mdu.busB;
`ifdef MULDIV_DIV_EN
        opValid  = mdu.start;
`else
        opValid  = mdu.start & ~mdu.op[1];
`endif
        acceptStart = (state == IDLE) & opValid;
    end

    // One shift-add step: multiplier sits in acc[31:0], partial product above it.
    always_comb begin
        mulSum  = acc[0] ? ({1'b0, acc[2*W-1:W]} + {1'b0, magB})
                         : {1'b0, acc[2*W-1:W]};
        mulStep = {mulSum, acc[W-1:1]};
        prodFix = negRes ? -acc : acc;
    end

`ifdef MULDIV_DIV_EN
    // One restoring divide step: remainder in acc[63:32], quotient shifts into acc[31:0].
    always_comb begin
        divUpper = acc[2*W-1:W-1];
        divGeq   = divUpper >= {1'b0, magB};
        divDiff  = divUpper[W-1:0] - magB;
        divStep  = divGeq ? {divDiff, acc[W-2:0], 1'b1}
                          : {divUpper[W-1:0], acc[W-2:0], 1'b0};
        quotFix  = negRes ? -acc[W-1:0] : acc[W-1:0];
        remFix   = negRem ? -acc[2*W-1:W] : acc[2*W-1:W];
    end
`endif

    // Next-state and next-register logic for the IDLE/RUN/FIX sequence.
    always_comb begin
        stateNext  = state;
        cntNext    = cnt;
        magBNext   = magB;
        negResNext = negRes;
        accNext    = acc;
        hiNext     = hiR;
        loNext     = loR;
        busyNext   = busyR;
        doneNext   = 1'b0;
`ifdef MULDIV_DIV_EN
        isDivNext  = isDiv;
        negRemNext = negRem;
        rawANext   = rawA;
`endif
        case (state)
            IDLE: begin
                if (acceptStart) begin
                    stateNext  = RUN;
                    cntNext    = '0;
                    magBNext   = magBIn;
                    negResNext = aNeg ^ bNeg;
                    accNext    = {W'(0), magAIn};
                    busyNext   = 1'b1;
`ifdef MULDIV_DIV_EN
                    isDivNext  = mdu.op[1];
                    negRemNext = aNeg;
                    rawANext   = mdu.busA;
`endif
                end else begin
                    // MTHI/MTLO only land when no operation is being launched.
                    if (mdu.hi_we) hiNext = mdu.wdata;
                    if (mdu.lo_we) loNext = mdu.wdata;
                end
            end
            RUN: begin
`ifdef MULDIV_DIV_EN
                accNext = isDiv ? divStep : mulStep;
`else
                accNext = mulStep;
`endif
                if (cnt == CNT_W'(LAST)) begin
                    stateNext = FIX;
                end else begin
                    cntNext = cnt + CNT_W'(1);
                end
            end
            FIX: begin
                stateNext = IDLE;
                busyNext  = 1'b0;
                doneNext  = 1'b1;
`ifdef MULDIV_DIV_EN
                if (isDiv) begin
                    // Divide by zero reports all-ones quotient and the raw dividend.
                    if (magB == '0) begin
                        hiNext = rawA;
                        loNext = '1;
                    end else begin
                        hiNext = remFix;
                        loNext = quotFix;
                    end
                end else begin
                    hiNext = prodFix[2*W-1:W];
                    loNext = prodFix[W-1:0];
                end
`else
                hiNext = prodFix[2*W-1:W];
                loNext = prodFix[W-1:0];
`endif
            end
            default: begin
                stateNext = IDLE;
                busyNext  = 1'b0;
            end
        endcase
    end

    // FSM state register.
    always_ff @(negedge clk or negedge clrn) begin
        if (!clrn) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Datapath, HI/LO and status registers.
    always_ff @(negedge clk or negedge clrn) begin
        if (!clrn) begin
            cnt    <= '0;
            magB   <= '0;
            negRes <= 1'b0;
            acc    <= '0;
            hiR    <= '0;
            loR    <= '0;
            busyR  <= 1'b0;
            doneR  <= 1'b0;
`ifdef MULDIV_DIV_EN
            isDiv  <= 1'b0;
            negRem <= 1'b0;
            rawA   <= '0;
`endif
        end else begin
            cnt    <= cntNext;
            magB   <= magBNext;
            negRes <= negResNext;
            acc    <= accNext;
            hiR    <= hiNext;
            loR    <= loNext;
            busyR  <= busyNext;
            doneR  <= doneNext;
`ifdef MULDIV_DIV_EN
            isDiv  <= isDivNext;
            negRem <= negRemNext;
            rawA   <= rawANext;
`endif
        end
    end

    assign mdu.hi   = hiR;
    assign mdu.lo   = loR;
    assign mdu.busy = busyR;
    assign mdu.done = doneR;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: randomized and directed checks of muldiv_unit against a
// plain-arithmetic reference model. Active edge is negedge clk; the bench
// drives and samples 1ns after each falling edge.
module tb_muldiv_unit;
    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    logic clk;
    logic clrn;
    int   tests = 0;
    int   fails = 0;

    muldiv_unit_if mdu();

    muldiv_unit dut (
        .clk  (clk),
        .clrn (clrn),
        .mdu  (mdu)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Reference: {hi, lo} from the architectural definition of each op.
    function automatic logic [63:0] refModel(input logic [1:0] o, input logic [31:0] a,
                                             input logic [31:0] b);
        longint sa;
        longint sb;
        longint q;
        longint r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            OP_MULT:  return 64'(sa * sb);
            OP_MULTU: return 64'(a) * 64'(b);
            OP_DIV: begin
                if (b == 32'h0) return {a, 32'hFFFFFFFF};
                q = sa / sb;
                r = sa % sb;
                return {32'(r), 32'(q)};
            end
            default: begin
                if (b == 32'h0) return {a, 32'hFFFFFFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [31:0] pickOperand();
        logic [31:0] v;
        case ($urandom_range(0, 5))
            0:       v = 32'h0;
            1:       v = 32'h80000000;
            2:       v = 32'hFFFFFFFF;
            3:       v = 32'($urandom_range(0, 20));
            default: v = $urandom;
        endcase
        return v;
    endfunction

    // Launch one op, scramble the buses, wait for done; edges counts the start edge as 1.
    task automatic runOp(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] rHi, output logic [31:0] rLo, output int edges);
        mdu.start = 1'b1;
        mdu.op    = o;
        mdu.busA  = a;
        mdu.busB  = b;
        mdu.hi_we = 1'b0;
        mdu.lo_we = 1'b0;
        tick();
        edges = 1;
        mdu.start = 1'b0;
        mdu.busA  = $urandom;
        mdu.busB  = $urandom;
        while (mdu.done !== 1'b1 && edges < 60) begin
            tick();
            edges++;
        end
        rHi = mdu.hi;
        rLo = mdu.lo;
    endtask

    task automatic test_reset();
        clrn      = 1'b0;
        mdu.start = 1'b0;
        mdu.op    = 2'b00;
        mdu.busA  = 32'h0;
        mdu.busB  = 32'h0;
        mdu.hi_we = 1'b0;
        mdu.lo_we = 1'b0;
        mdu.wdata = 32'h0;
        tick();
        tick();
        tests++; if (mdu.hi !== 32'h0) begin fails++; $display("FAIL reset_hi got=%h want=%h", mdu.hi, 32'h0); end
        tests++; if (mdu.lo !== 32'h0) begin fails++; $display("FAIL reset_lo got=%h want=%h", mdu.lo, 32'h0); end
        tests++; if (mdu.busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b want=0", mdu.busy); end
        tests++; if (mdu.done !== 1'b0) begin fails++; $display("FAIL reset_done got=%b want=0", mdu.done); end
        clrn = 1'b1;
        tick();
    endtask

    task automatic test_mthi_mtlo();
        mdu.wdata = 32'hA5A50001;
        mdu.hi_we = 1'b1;
        tick();
        mdu.hi_we = 1'b0;
        tests++; if (mdu.hi !== 32'hA5A50001) begin fails++; $display("FAIL mthi got=%h want=%h", mdu.hi, 32'hA5A50001); end
        tests++; if (mdu.lo !== 32'h0) begin fails++; $display("FAIL mthi_lo_held got=%h want=%h", mdu.lo, 32'h0); end
        mdu.wdata = 32'h5A5A0002;
        mdu.lo_we = 1'b1;
        tick();
        mdu.lo_we = 1'b0;
        tests++; if (mdu.lo !== 32'h5A5A0002) begin fails++; $display("FAIL mtlo got=%h want=%h", mdu.lo, 32'h5A5A0002); end
        tests++; if (mdu.hi !== 32'hA5A50001) begin fails++; $display("FAIL mtlo_hi_held got=%h want=%h", mdu.hi, 32'hA5A50001); end
    endtask

    task automatic test_multu_latency();
        int badMid;
        mdu.start = 1'b1;
        mdu.op    = OP_MULTU;
        mdu.busA  = 32'hFFFFFFFF;
        mdu.busB  = 32'hFFFFFFFF;
        tick();
        mdu.start = 1'b0;
        mdu.busA  = $urandom;
        mdu.busB  = $urandom;
        tests++; if (mdu.busy !== 1'b1) begin fails++; $display("FAIL lat_busy_rise got=%b want=1", mdu.busy); end
        badMid = 0;
        for (int e = 2; e <= 33; e++) begin
            tick();
            if (mdu.done !== 1'b0 || mdu.busy !== 1'b1 ||
                mdu.hi !== 32'hA5A50001 || mdu.lo !== 32'h5A5A0002) badMid++;
        end
        tests++; if (badMid != 0) begin fails++; $display("FAIL lat_midflight bad_edges=%0d want=0", badMid); end
        tick();
        tests++; if (mdu.done !== 1'b1) begin fails++; $display("FAIL lat_done_edge34 got=%b want=1", mdu.done); end
        tests++; if (mdu.hi !== 32'hFFFFFFFE) begin fails++; $display("FAIL multu_max_hi got=%h want=%h", mdu.hi, 32'hFFFFFFFE); end
        tests++; if (mdu.lo !== 32'h00000001) begin fails++; $display("FAIL multu_max_lo got=%h want=%h", mdu.lo, 32'h1); end
        tests++; if (mdu.busy !== 1'b0) begin fails++; $display("FAIL lat_busy_fall got=%b want=0", mdu.busy); end
        tick();
        tests++; if (mdu.done !== 1'b0) begin fails++; $display("FAIL lat_done_pulse got=%b want=0", mdu.done); end
    endtask

    task automatic test_mult_signed();
        logic [31:0] rHi, rLo;
        int edges;
        runOp(OP_MULT, 32'hFFFFFFFD, 32'd7, rHi, rLo, edges);
        tests++; if (edges != 34) begin fails++; $display("FAIL mult_signed_latency got=%0d want=34", edges); end
        tests++; if (rHi !== 32'hFFFFFFFF) begin fails++; $display("FAIL mult_signed_hi got=%h want=%h", rHi, 32'hFFFFFFFF); end
        tests++; if (rLo !== 32'hFFFFFFEB) begin fails++; $display("FAIL mult_signed_lo got=%h want=%h", rLo, 32'hFFFFFFEB); end
    endtask

    // Random MULT/MULTU launched back to back, each starting right after the previous done.
    task automatic test_random_mul();
        logic [31:0] a, b, rHi, rLo;
        logic [1:0]  o;
        logic [63:0] exp;
        int edges;
        for (int i = 0; i < 20; i++) begin
            o   = 2'($urandom_range(0, 1));
            a   = pickOperand();
            b   = pickOperand();
            exp = refModel(o, a, b);
            runOp(o, a, b, rHi, rLo, edges);
            tests++;
            if ({rHi, rLo} !== exp || edges != 34) begin
                fails++;
                $display("FAIL rand_mul op=%0d a=%h b=%h got=%h_%h edges=%0d want=%h edges=34",
                         o, a, b, rHi, rLo, edges, exp);
            end
        end
    endtask

    task automatic test_busy_ignore();
        int edges;
        int extraDone;
        mdu.start = 1'b1;
        mdu.op    = OP_MULTU;
        mdu.busA  = 32'd5;
        mdu.busB  = 32'd6;
        tick();
        edges = 1;
        mdu.start = 1'b0;
        for (int c = 2; c <= 4; c++) begin tick(); edges++; end
        mdu.start = 1'b1;
        mdu.busA  = 32'd9;
        mdu.busB  = 32'd9;
        mdu.hi_we = 1'b1;
        mdu.lo_we = 1'b1;
        mdu.wdata = 32'hDEADBEEF;
        tick();
        edges++;
        mdu.start = 1'b0;
        mdu.hi_we = 1'b0;
        mdu.lo_we = 1'b0;
        tests++; if (mdu.hi === 32'hDEADBEEF) begin fails++; $display("FAIL busy_mthi_taken got=%h", mdu.hi); end
        while (mdu.done !== 1'b1 && edges < 60) begin tick(); edges++; end
        tests++; if (edges != 34) begin fails++; $display("FAIL busy_ignore_latency got=%0d want=34", edges); end
        tests++; if (mdu.hi !== 32'h0) begin fails++; $display("FAIL busy_ignore_hi got=%h want=%h", mdu.hi, 32'h0); end
        tests++; if (mdu.lo !== 32'h1E) begin fails++; $display("FAIL busy_ignore_lo got=%h want=%h", mdu.lo, 32'h1E); end
        extraDone = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (mdu.done !== 1'b0 || mdu.busy !== 1'b0) extraDone++;
        end
        tests++; if (extraDone != 0) begin fails++; $display("FAIL busy_ignore_second_op active_cycles=%0d want=0", extraDone); end
    endtask

    task automatic test_reset_midop();
        logic [31:0] rHi, rLo;
        int edges;
        int bad;
        mdu.start = 1'b1;
        mdu.op    = OP_MULTU;
        mdu.busA  = 32'd5;
        mdu.busB  = 32'd6;
        tick();
        mdu.start = 1'b0;
        for (int c = 2; c <= 10; c++) tick();
        #1 clrn = 1'b0;
        #1;
        tests++; if (mdu.busy !== 1'b0) begin fails++; $display("FAIL midreset_busy got=%b want=0", mdu.busy); end
        tests++; if (mdu.hi !== 32'h0) begin fails++; $display("FAIL midreset_hi got=%h want=%h", mdu.hi, 32'h0); end
        tests++; if (mdu.lo !== 32'h0) begin fails++; $display("FAIL midreset_lo got=%h want=%h", mdu.lo, 32'h0); end
        tests++; if (mdu.done !== 1'b0) begin fails++; $display("FAIL midreset_done got=%b want=0", mdu.done); end
        #1 clrn = 1'b1;
        bad = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (mdu.done !== 1'b0 || mdu.busy !== 1'b0 || mdu.hi !== 32'h0 || mdu.lo !== 32'h0) bad++;
        end
        tests++; if (bad != 0) begin fails++; $display("FAIL midreset_discard bad_cycles=%0d want=0", bad); end
        runOp(OP_MULTU, 32'd3, 32'd4, rHi, rLo, edges);
        tests++;
        if (rHi !== 32'h0 || rLo !== 32'd12 || edges != 34) begin
            fails++;
            $display("FAIL post_reset_op got=%h_%h edges=%0d want=%h_%h edges=34", rHi, rLo, edges, 32'h0, 32'd12);
        end
    endtask

    task automatic test_start_wins();
        int edges;
        mdu.start = 1'b1;
        mdu.op    = OP_MULTU;
        mdu.busA  = 32'h00010000;
        mdu.busB  = 32'h00010000;
        mdu.hi_we = 1'b1;
        mdu.lo_we = 1'b1;
        mdu.wdata = 32'hABCD1234;
        tick();
        edges = 1;
        mdu.start = 1'b0;
        mdu.hi_we = 1'b0;
        mdu.lo_we = 1'b0;
        tests++;
        if (mdu.hi !== 32'h0 || mdu.lo !== 32'd12 || mdu.busy !== 1'b1) begin
            fails++;
            $display("FAIL start_wins_write got hi=%h lo=%h busy=%b want hi=%h lo=%h busy=1",
                     mdu.hi, mdu.lo, mdu.busy, 32'h0, 32'd12);
        end
        while (mdu.done !== 1'b1 && edges < 60) begin tick(); edges++; end
        tests++;
        if (mdu.hi !== 32'h1 || mdu.lo !== 32'h0 || edges != 34) begin
            fails++;
            $display("FAIL start_wins_result got=%h_%h edges=%0d want=%h_%h edges=34", mdu.hi, mdu.lo, edges, 32'h1, 32'h0);
        end
    endtask

`ifdef MULDIV_DIV_EN
    task automatic test_div_directed();
        logic [1:0]  ops  [5];
        logic [31:0] as   [5];
        logic [31:0] bs   [5];
        logic [31:0] eHi  [5];
        logic [31:0] eLo  [5];
        logic [31:0] rHi, rLo;
        int edges;
        ops[0] = OP_DIV;  as[0] = 32'hFFFFFFF9; bs[0] = 32'd2;        eHi[0] = 32'hFFFFFFFF; eLo[0] = 32'hFFFFFFFD;
        ops[1] = OP_DIVU; as[1] = 32'd100;      bs[1] = 32'd7;        eHi[1] = 32'h2;        eLo[1] = 32'hE;
        ops[2] = OP_DIV;  as[2] = 32'h00001234; bs[2] = 32'h0;        eHi[2] = 32'h00001234; eLo[2] = 32'hFFFFFFFF;
        ops[3] = OP_DIV;  as[3] = 32'h80000000; bs[3] = 32'hFFFFFFFF; eHi[3] = 32'h0;        eLo[3] = 32'h80000000;
        ops[4] = OP_DIV;  as[4] = 32'hFFFFFF00; bs[4] = 32'h0;        eHi[4] = 32'hFFFFFF00; eLo[4] = 32'hFFFFFFFF;
        for (int i = 0; i < 5; i++) begin
            runOp(ops[i], as[i], bs[i], rHi, rLo, edges);
            tests++;
            if (rHi !== eHi[i] || rLo !== eLo[i] || edges != 34) begin
                fails++;
                $display("FAIL div_directed_%0d got=%h_%h edges=%0d want=%h_%h edges=34",
                         i, rHi, rLo, edges, eHi[i], eLo[i]);
            end
        end
    endtask

    task automatic test_random_div();
        logic [31:0] a, b, rHi, rLo;
        logic [1:0]  o;
        logic [63:0] exp;
        int edges;
        for (int i = 0; i < 20; i++) begin
            o   = 2'($urandom_range(2, 3));
            a   = pickOperand();
            b   = pickOperand();
            exp = refModel(o, a, b);
            runOp(o, a, b, rHi, rLo, edges);
            tests++;
            if ({rHi, rLo} !== exp || edges != 34) begin
                fails++;
                $display("FAIL rand_div op=%0d a=%h b=%h got=%h_%h edges=%0d want=%h edges=34",
                         o, a, b, rHi, rLo, edges, exp);
            end
        end
    endtask
`else
    task automatic test_div_disabled();
        logic [31:0] rHi, rLo;
        int busyCnt;
        int doneCnt;
        int edges;
        mdu.wdata = 32'h11112222;
        mdu.hi_we = 1'b1;
        tick();
        mdu.hi_we = 1'b0;
        mdu.wdata = 32'h33334444;
        mdu.lo_we = 1'b1;
        tick();
        mdu.lo_we = 1'b0;
        busyCnt = 0;
        doneCnt = 0;
        mdu.start = 1'b1;
        mdu.op    = OP_DIVU;
        mdu.busA  = 32'd100;
        mdu.busB  = 32'd7;
        tick();
        mdu.start = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (mdu.busy !== 1'b0) busyCnt++;
            if (mdu.done !== 1'b0) doneCnt++;
            tick();
        end
        tests++; if (busyCnt != 0) begin fails++; $display("FAIL divdis_busy cycles=%0d want=0", busyCnt); end
        tests++; if (doneCnt != 0) begin fails++; $display("FAIL divdis_done cycles=%0d want=0", doneCnt); end
        tests++; if (mdu.hi !== 32'h11112222) begin fails++; $display("FAIL divdis_hi got=%h want=%h", mdu.hi, 32'h11112222); end
        tests++; if (mdu.lo !== 32'h33334444) begin fails++; $display("FAIL divdis_lo got=%h want=%h", mdu.lo, 32'h33334444); end
        runOp(OP_MULTU, 32'd6, 32'd7, rHi, rLo, edges);
        tests++;
        if (rHi !== 32'h0 || rLo !== 32'd42 || edges != 34) begin
            fails++;
            $display("FAIL divdis_mul_after got=%h_%h edges=%0d want=%h_%h edges=34", rHi, rLo, edges, 32'h0, 32'd42);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_mthi_mtlo();
        test_multu_latency();
        test_mult_signed();
        test_random_mul();
        test_busy_ignore();
        test_reset_midop();
        test_start_wins();
`ifdef MULDIV_DIV_EN
        test_div_directed();
        test_random_div();
`else
        test_div_disabled();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
